// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: two-master round-robin Wishbone arbiter with address
// translation onto SLAVE_BASE and a per-transfer watchdog.
`default_nettype none

module wb_master_arbiter #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 16,
  parameter logic [31:0] SLAVE_BASE = 32'h40000000,
  parameter int          TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [DATA_WIDTH-1:0]   m0_dat_w,
  output logic [DATA_WIDTH-1:0]   m0_dat_r,
  input  logic                    m0_we,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [DATA_WIDTH-1:0]   m1_dat_w,
  output logic [DATA_WIDTH-1:0]   m1_dat_r,
  input  logic                    m1_we,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic [31:0]             s_adr,
  output logic [DATA_WIDTH-1:0]   s_dat_w,
  input  logic [DATA_WIDTH-1:0]   s_dat_r,
  output logic                    s_we,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  input  logic                    s_ack,
  input  logic                    s_err,
  output logic [1:0]              grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);

  state_t                  r_state;
  logic [1:0]              r_grant;
  logic                    r_last;
  logic [15:0]             r_cnt;
  logic                    r_to_err;

  logic                    w_sel0;
  logic                    w_sel1;
  logic                    w_own_cyc;
  logic                    w_own_stb;
  logic                    w_own_we;
  logic [ADDR_WIDTH-1:0]   w_own_adr;
  logic [DATA_WIDTH-1:0]   w_own_dat;
  logic                    w_active;
  logic                    w_stall;

  assign w_sel0    = r_grant[0];
  assign w_sel1    = r_grant[1];
  assign w_own_cyc = (w_sel0 & m0_cyc) | (w_sel1 & m1_cyc);
  assign w_own_stb = (w_sel0 & m0_stb) | (w_sel1 & m1_stb);
  assign w_own_we  = (w_sel0 & m0_we)  | (w_sel1 & m1_we);
  assign w_own_adr = w_sel0 ? m0_adr   : (w_sel1 ? m1_adr   : '0);
  assign w_own_dat = w_sel0 ? m0_dat_w : (w_sel1 ? m1_dat_w : '0);

  // Slave side is live only while the owner holds cyc in OWN; ABORT keeps it idle.
  assign w_active = (r_state == ST_OWN) & w_own_cyc;
  assign w_stall  = w_active & w_own_stb & ~s_ack & ~s_err;

  assign s_cyc   = w_active;
  assign s_stb   = w_active & w_own_stb;
  assign s_we    = w_active & w_own_we;
  assign s_adr   = SLAVE_BASE + 32'(w_own_adr);
  assign s_dat_w = w_own_dat;
  assign s_sel   = '1;
  assign grant   = r_grant;

  assign m0_ack   = w_sel0 & w_active & s_ack;
  assign m1_ack   = w_sel1 & w_active & s_ack;
  assign m0_err   = w_sel0 & ((w_active & s_err) | r_to_err);
  assign m1_err   = w_sel1 & ((w_active & s_err) | r_to_err);
  assign m0_dat_r = w_sel0 ? s_dat_r : '0;
  assign m1_dat_r = w_sel1 ? s_dat_r : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_cnt    <= 16'd0;
      r_to_err <= 1'b0;
    end else begin
      r_to_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 16'd0;
          // On a tie the master that did not own the port last time wins.
          if (m0_cyc && (!m1_cyc || r_last)) begin
            r_grant <= 2'b01;
            r_state <= ST_OWN;
          end else if (m1_cyc) begin
            r_grant <= 2'b10;
            r_state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!w_own_cyc) begin
            r_last  <= w_sel1;
            r_grant <= 2'b00;
            r_cnt   <= 16'd0;
            r_state <= ST_IDLE;
          end else if (w_stall) begin
            // Abort after TIMEOUT stalled cycles; the err pulse and the idle
            // slave bus appear together in the first ABORT cycle.
            if (r_cnt == C_TO_LAST) begin
              r_cnt    <= 16'd0;
              r_to_err <= 1'b1;
              r_state  <= ST_ABORT;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end else begin
            r_cnt <= 16'd0;
          end
        end
        ST_ABORT: begin
          if (!w_own_cyc) begin
            r_last  <= w_sel1;
            r_grant <= 2'b00;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant <= 2'b00;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: scoreboard bench for wb_master_arbiter (TIMEOUT = 4).
`default_nettype none

module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] m0_adr, m1_adr, m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r;
  logic        m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] s_adr;
  logic [15:0] s_dat_w, s_dat_r;
  logic        s_we, s_cyc, s_stb, s_ack, s_err;
  logic [1:0]  s_sel, grant;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  wb_master_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .SLAVE_BASE(32'h40000000), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_we(s_we),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_sel(s_sel), .s_ack(s_ack), .s_err(s_err),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change at negedge+1; this monitor samples at the negedge.
  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", {62'd0, m1_ack, m0_ack}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_ack_id", {62'd0, m1_ack, m0_ack}, {62'd0, e.id});
        check("sb_rdata", m0_ack ? m0_dat_r : m1_dat_r, e.dat);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    m0_adr = '0; m1_adr = '0; m0_dat_w = '0; m1_dat_w = '0;
    m0_we = 0; m1_we = 0; m0_cyc = 0; m1_cyc = 0; m0_stb = 0; m1_stb = 0;
    s_dat_r = '0; s_ack = 0; s_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    step(2);
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_s_stb", s_stb, 0);
    check("rst_s_we", s_we, 0);
    check("rst_acks_errs", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0);
    reset = 1'b1;
    step(1);

    // Single write from m0
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 16'h0010; m0_dat_w = 16'hBEEF;
    #1;
    check("wr_s_cyc_latency", s_cyc, 0);
    step(1);
    check("wr_grant", grant, 2'b01);
    check("wr_s_cyc", s_cyc, 1);
    check("wr_s_adr", s_adr, 32'h40000010);
    check("wr_s_we", s_we, 1);
    check("wr_s_sel", s_sel, 2'b11);
    check("wr_s_dat_w", s_dat_w, 16'hBEEF);
    s_ack = 1; sb_q.push_back('{2'b01, 16'h0000});
    #1;
    check("wr_m0_ack", m0_ack, 1);
    check("wr_m1_ack", m1_ack, 0);
    step(1);
    s_ack = 0; m0_stb = 0; m0_cyc = 0; m0_we = 0;
    step(1);
    check("wr_release_grant", grant, 2'b00);

    // Tie out of reset, then alternation
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    step(1);
    check("tie1_grant", grant, 2'b01);
    m0_cyc = 0;
    step(1);
    check("tie1_dead_cycle", grant, 2'b00);
    step(1);
    check("tie1_m1_granted", grant, 2'b10);
    m0_cyc = 1;
    step(1);
    check("m1_holds", grant, 2'b10);
    m1_cyc = 0;
    step(1);
    check("tie2_dead_cycle", grant, 2'b00);
    m1_cyc = 1;
    step(1);
    check("tie2_grant", grant, 2'b01);
    m0_cyc = 0; m1_cyc = 0;
    step(2);

    // Grant lock across three reads with m1 waiting
    m0_cyc = 1;
    step(1);
    check("lock_grant0", grant, 2'b01);
    m1_cyc = 1; m1_stb = 1;
    foreach (sb_q[i]) ;
    for (int k = 1; k <= 3; k++) begin
      logic [15:0] v;
      v = 16'(k * 16'h1111);
      m0_stb = 1; m0_adr = 16'(k);
      step(1);
      s_ack = 1; s_dat_r = v; sb_q.push_back('{2'b01, v});
      #1;
      check("lock_m1_dat_r", m1_dat_r, 16'h0000);
      step(1);
      check("lock_grant", grant, 2'b01);
      s_ack = 0; m0_stb = 0;
      step(1);
    end
    m0_cyc = 0;
    step(1);
    check("lock_release", grant, 2'b00);
    step(1);
    check("lock_m1_next", grant, 2'b10);
    m1_cyc = 0; m1_stb = 0; s_dat_r = '0;
    step(2);

    // Ack arrives on the last allowed stalled cycle: ack wins
    m0_cyc = 1;
    step(1);
    check("race_grant", grant, 2'b01);
    m0_stb = 1;
    step(3);
    s_ack = 1; s_dat_r = 16'hA5A5; sb_q.push_back('{2'b01, 16'hA5A5});
    #1;
    check("race_m0_ack", m0_ack, 1);
    check("race_m0_err", m0_err, 0);
    step(1);
    s_ack = 0; m0_stb = 0;
    #1;
    check("race_still_own", s_cyc, 1);
    check("race_no_err", m0_err, 0);

    // Timeout: slave never responds
    m0_stb = 1;
    step(3);
    check("to_no_err_early", m0_err, 0);
    check("to_s_cyc_early", s_cyc, 1);
    step(1);
    check("to_err_pulse", m0_err, 1);
    check("to_s_cyc_drop", s_cyc, 0);
    check("to_s_stb_drop", s_stb, 0);
    check("to_grant_held", grant, 2'b01);
    step(1);
    check("to_err_one_clk", m0_err, 0);
    check("to_abort_grant", grant, 2'b01);
    check("to_abort_idle_bus", s_stb, 0);
    m0_cyc = 0; m0_stb = 0;
    step(1);
    check("to_exit_grant", grant, 2'b00);

    // Asynchronous reset in the middle of a transfer
    m0_cyc = 1; m0_stb = 1;
    step(1);
    check("ar_s_stb_before", s_stb, 1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_s_cyc", s_cyc, 0);
    check("ar_s_stb", s_stb, 0);
    check("ar_grant", grant, 2'b00);
    step(1);
    idle_inputs();
    reset = 1'b1;
    m1_cyc = 1; m1_stb = 1; m1_adr = 16'h0020;
    step(1);
    check("ar_m1_grant", grant, 2'b10);
    check("ar_m1_adr", s_adr, 32'h40000020);
    s_ack = 1; s_dat_r = 16'h5A5A; sb_q.push_back('{2'b10, 16'h5A5A});
    step(1);
    s_ack = 0; m1_stb = 0; m1_cyc = 0;
    step(2);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
